// File: rtl/multiword_add_seq.sv
// Byte-serial multi-precision adder: chains an 8-bit ripple-carry adder across operand bytes, LSB first.
// Optional signed-overflow output (out_ovf) is enabled by defining MULTIWORD_ADD_OVF_EN.

module multiword_add_seq_rca8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [8:0] c;

  always_comb begin
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[8];
  end
endmodule

module multiword_add_seq #(
  parameter int MAX_BYTES = 8,
  parameter int IDX_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_cin,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_sum,
  output logic             out_cout,
  output logic             out_last,
  output logic [IDX_W-1:0] out_idx,
`ifdef MULTIWORD_ADD_OVF_EN
  output logic             out_ovf,
`endif
  output logic             err
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [IDX_W-1:0] CNT_MAX = IDX_W'(MAX_BYTES - 1);

  state_t           state_q, state_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] cnt_q, cnt_d, cnt_nx;
  logic             err_q, err_d;
  logic             vld_q, vld_d;
  logic [7:0]       sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             last_q, last_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             starts;
  logic             add_cin;
  logic [7:0]       add_sum;
  logic             add_cout;

  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready;
  // A beat opens a new frame when no frame is open or when it is marked first.
  assign starts   = (state_q == IDLE) || in_first;
  assign add_cin  = starts ? in_cin : carry_q;

  multiword_add_seq_rca8 u_rca (
    .a    (in_a),
    .b    (in_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cnt_nx  = cnt_q;
    err_d   = err_q;
    vld_d   = vld_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    last_d  = last_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    if (accept) begin
      if (starts) begin
        cnt_nx = '0;
        err_d  = (state_q == IDLE) ? !in_first : 1'b1;
      end else if (cnt_q == CNT_MAX) begin
        cnt_nx = cnt_q;
        err_d  = 1'b1;
      end else begin
        cnt_nx = cnt_q + 1'b1;
      end
      vld_d   = 1'b1;
      sum_d   = add_sum;
      cout_d  = add_cout;
      last_d  = in_last;
      carry_d = add_cout;
      cnt_d   = cnt_nx;
      idx_d   = cnt_nx;
      state_d = in_last ? IDLE : BUSY;
      ovf_d   = in_last & ((in_a[7] ~^ in_b[7]) & (add_sum[7] ^ in_a[7]));
    end else if (vld_q && out_ready) begin
      vld_d = 1'b0;
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = vld_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_last  = last_q;
  assign out_idx   = idx_q;
  assign err       = err_q;
`ifdef MULTIWORD_ADD_OVF_EN
  assign out_ovf   = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq: directed protocol steps plus random frames checked against arithmetic sums.
// Build with MULTIWORD_ADD_OVF_EN defined to also check out_ovf.
module tb_multiword_add_seq;
  localparam int MAXB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       in_cin = 1'b0;
  logic       in_first = 1'b0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_sum;
  logic       out_cout;
  logic       out_last;
  logic [2:0] out_idx;
  logic       err;
  logic       out_ovf;

  always #5 clk = ~clk;

  multiword_add_seq #(.MAX_BYTES(MAXB), .IDX_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_last  (out_last),
    .out_idx   (out_idx),
`ifdef MULTIWORD_ADD_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .err       (err)
  );
`ifndef MULTIWORD_ADD_OVF_EN
  assign out_ovf = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  logic       m_open = 1'b0;
  logic       m_carry = 1'b0;
  int         m_cnt = 0;
  logic       exp_vld = 1'b0;
  logic [7:0] exp_sum = '0;
  logic       exp_cout = 1'b0;
  logic       exp_last = 1'b0;
  int         exp_idx = 0;
  logic       exp_err = 1'b0;
  logic       exp_ovf = 1'b0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_carry = 0; m_cnt = 0;
    exp_vld = 0; exp_sum = 0; exp_cout = 0; exp_last = 0; exp_idx = 0; exp_err = 0; exp_ovf = 0;
  endtask

  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic c, input logic f, input logic l);
    logic [8:0] s;
    logic       ci;
    ci = (!m_open || f) ? c : m_carry;
    s  = {1'b0, a} + {1'b0, b} + {8'b0, ci};
    if (!m_open) begin
      exp_err = !f; m_cnt = 0;
    end else if (f) begin
      exp_err = 1; m_cnt = 0;
    end else if (m_cnt == MAXB - 1) begin
      exp_err = 1;
    end else begin
      m_cnt++;
    end
    m_open   = !l;
    m_carry  = s[8];
    exp_vld  = 1;
    exp_sum  = s[7:0];
    exp_cout = s[8];
    exp_last = l;
    exp_idx  = m_cnt;
    exp_ovf  = l && (a[7] == b[7]) && (s[7] != a[7]);
  endtask

  task automatic check_out(input string t);
    chk({t, ".valid"}, 72'(out_valid), 72'(exp_vld));
    chk({t, ".sum"},   72'(out_sum),   72'(exp_sum));
    chk({t, ".cout"},  72'(out_cout),  72'(exp_cout));
    chk({t, ".last"},  72'(out_last),  72'(exp_last));
    chk({t, ".idx"},   72'(out_idx),   72'(exp_idx));
    chk({t, ".err"},   72'(err),       72'(exp_err));
`ifdef MULTIWORD_ADD_OVF_EN
    chk({t, ".ovf"},   72'(out_ovf),   72'(exp_ovf));
`endif
  endtask

  task automatic beat(input string t, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic f, input logic l);
    @(negedge clk);
    in_valid = 1; in_a = a; in_b = b; in_cin = c; in_first = f; in_last = l;
    model(a, b, c, f, l);
    @(posedge clk); #1;
    in_valid = 0;
    check_out(t);
  endtask

  logic [63:0] fa, fb;
  logic [71:0] tot, res, mask;
  logic [7:0]  ra, rb;
  logic        rc;
  int          len;

  initial begin
    #2 rst_n = 0;
    #1;
    model_reset();
    check_out("reset");
    chk("reset.in_ready", 72'(in_ready), 72'(1));
    @(negedge clk); rst_n = 1;

    beat("single", 8'h01, 8'h01, 0, 1, 1);
    beat("single_cin", 8'h01, 8'h01, 1, 1, 1);

    beat("chain0", 8'hFF, 8'h01, 0, 1, 0);
    beat("chain1", 8'h01, 8'h00, 0, 0, 1);
    beat("ffff0", 8'hFF, 8'hFF, 0, 1, 0);
    beat("ffff1", 8'hFF, 8'hFF, 0, 0, 1);

    @(posedge clk); #1;
    exp_vld = 0;
    check_out("idle_drop");

    // Backpressure: hold the first result for three cycles while a new beat waits
    beat("bp0", 8'h10, 8'h20, 0, 1, 0);
    @(negedge clk);
    out_ready = 0;
    in_valid = 1; in_a = 8'h30; in_b = 8'h40; in_cin = 1; in_first = 0; in_last = 1;
    #1 chk("bp.in_ready_low", 72'(in_ready), 72'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_out("bp_hold");
      chk("bp.in_ready_hold", 72'(in_ready), 72'(0));
    end
    @(negedge clk);
    out_ready = 1;
    model(8'h30, 8'h40, 1, 0, 1);
    #1 chk("bp.in_ready_release", 72'(in_ready), 72'(1));
    @(posedge clk); #1;
    in_valid = 0;
    check_out("bp_release");
    @(posedge clk); #1;
    exp_vld = 0;
    check_out("bp_drain");

    // Missing first beat in IDLE, then a clean frame clears err
    beat("nofirst", 8'h05, 8'h06, 1, 0, 1);
    beat("clean", 8'h11, 8'h22, 0, 1, 1);

    // Abandon an open frame
    beat("abandon0", 8'h80, 8'h80, 0, 1, 0);
    beat("abandon1", 8'h01, 8'h02, 1, 1, 1);
    beat("clean2", 8'h00, 8'h00, 0, 1, 1);

    // Length overflow: MAX_BYTES+1 non-last beats, then close
    beat("ovfl_first", 8'h01, 8'h02, 0, 1, 0);
    for (int i = 1; i <= MAXB; i++) beat("ovfl_mid", 8'($urandom), 8'($urandom), 0, 0, 0);
    beat("ovfl_last", 8'hAA, 8'h55, 0, 0, 1);
    beat("clean3", 8'h7F, 8'h01, 0, 1, 1);

    // Signed overflow cases
    beat("sovf_80", 8'h80, 8'h80, 0, 1, 1);
    beat("sovf_01", 8'h01, 8'h01, 0, 1, 1);

    // Reset in the middle of a 4-byte frame
    beat("mid0", 8'h12, 8'h34, 0, 1, 0);
    #2 rst_n = 0;
    #1;
    model_reset();
    check_out("midreset");
    @(negedge clk); rst_n = 1;
    beat("after_reset", 8'h05, 8'h06, 1, 0, 1);
    beat("after_clean", 8'h01, 8'h01, 0, 1, 1);

    // Random well-formed frames checked byte-wise and as whole-frame sums
    for (int fr = 0; fr < 40; fr++) begin
      len = $urandom_range(1, MAXB);
      rc  = 1'($urandom);
      fa = '0; fb = '0; res = '0;
      for (int i = 0; i < len; i++) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        fa = fa | (64'(ra) << (8 * i));
        fb = fb | (64'(rb) << (8 * i));
        beat("rand", ra, rb, rc, i == 0, i == len - 1);
        res = res | (72'(out_sum) << (8 * i));
      end
      tot  = {8'b0, fa} + {8'b0, fb} + 72'(rc);
      mask = (72'(1) << (8 * len)) - 72'(1);
      chk("frame.sum", res, tot & mask);
      chk("frame.cout", 72'(out_cout), (tot >> (8 * len)) & 72'(1));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        exp_vld = 0;
        check_out("rand_gap");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/multiword_add_seq.md
Name: multiword_add_seq

Overview:
- Byte-serial multi-precision adder controller. It accepts operand byte pairs least-significant first and drives one instance of the 8-bit ripplecarry adder (ports a, b, cin, sum, cout).
- It chains each byte's carry-out into the next byte's carry-in and returns one registered sum byte per input beat.
- Sits between an operand source (e.g. a register file or UART loader) and a result sink. Used to build 16/32/64-bit additions from the existing 8-bit adder.

Parameters:
- MAX_BYTES, 8, maximum beats per frame (operand width = 8*MAX_BYTES bits).
- IDX_W, 3, width of out_idx; must satisfy 2**IDX_W >= MAX_BYTES.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_a  in  8  operand A byte
- in_b  in  8  operand B byte
- in_cin  in  1  frame carry-in; used only on the first beat
- in_first  in  1  beat is the least-significant byte of a frame
- in_last  in  1  beat is the most-significant byte of a frame
- out_valid  out  1  result beat valid
- out_ready  in  1  sink accepts result
- out_sum  out  8  sum byte
- out_cout  out  1  carry-out of this byte
- out_last  out  1  copy of in_last for this beat
- out_idx  out  IDX_W  byte index within frame (0 = LSB)
- err  out  1  protocol error flag

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_sum=0, out_cout=0, out_last=0, out_idx=0, err=0, carry_q=0, cnt=0, state=IDLE. Outputs take effect immediately, without waiting for a clock edge.
- Single output register stage with no skid buffer: in_ready = !out_valid || out_ready (combinational).
- accept = in_valid && in_ready.
- Latency: 1 cycle. A beat accepted at edge N appears on the outputs after edge N.
- Adder inputs:
  - a = in_a, b = in_b.
  - cin = in_cin when the beat starts a frame; otherwise carry_q.
- On accept:
  - out_sum <= sum, out_cout <= cout, out_last <= in_last, out_valid <= 1.
  - carry_q <= cout.
  - out_idx <= cnt_next; cnt <= cnt_next.
- No accept but out_valid && out_ready: out_valid <= 0. All other outputs hold.
- Output stability: out_* remain stable while out_valid && !out_ready.
- FSM states: IDLE (no frame open), BUSY (frame open).
- IDLE, accepted beat:
  - The beat starts a frame: cnt_next=0, cin=in_cin.
  - If in_first=0, err <= 1 (missing-first), and the beat is still processed as a first beat.
  - If in_last=1, stay IDLE (single-byte frame); else go to BUSY.
- BUSY, accepted beat with in_first=1:
  - Abandon the open frame, err <= 1, restart with cin=in_cin and cnt_next=0.
  - Next state follows in_last as in IDLE.
- BUSY, accepted beat with in_first=0:
  - cin=carry_q.
  - cnt_next = cnt+1, saturating at MAX_BYTES-1.
  - If cnt == MAX_BYTES-1, err <= 1 (length overflow); the addition is still performed.
  - If in_last=1, go to IDLE.
- err is sticky. It clears only on reset or on an error-free first beat accepted in IDLE (err <= 0 at that edge).
- in_first and in_last may both be 1: single-byte frame, cin=in_cin, out_idx=0.
- Arithmetic is modulo 256 per byte. No sign handling without the optional feature.
- in_* are ignored when not accepted.

Optional Feature:
- Macro: MULTIWORD_ADD_OVF_EN.
- Defined:
  - Adds output port out_ovf (out, 1), reset value 0.
  - On each accepted beat with in_last=1, out_ovf <= in_a[7] ~^ in_b[7] & (sum[7] ^ in_a[7]) (two's-complement signed overflow of the full frame).
  - On beats with in_last=0, out_ovf <= 0.
  - out_ovf follows the same hold rules as out_sum.
- Undefined: port absent, no extra logic.

Test Plan:
- Single byte: a=0x01, b=0x01, cin=0, first=last=1 -> out_sum=0x02, out_cout=0, out_idx=0, err=0. Repeat with cin=1 -> out_sum=0x03.
- Two-byte carry chain, 0x01FF + 0x0001:
  - Beat 0 (FF,01, first) -> sum 0x00, cout 1, idx 0.
  - Beat 1 (01,00, last) -> sum 0x02, cout 0, idx 1, out_last=1.
  - Then 0xFFFF + 0xFFFF -> bytes 0xFE/cout1, then 0xFF/cout1.
- Backpressure: out_ready=0 for 3 cycles after the first result -> in_ready=0, outputs frozen. Release -> next beat accepted the same cycle out_ready rises. No beat lost or duplicated.
- Protocol errors:
  - Non-first beat in IDLE -> err=1, sum uses in_cin.
  - Subsequent clean first beat -> err=0.
  - MAX_BYTES+1 non-last beats -> err=1 at beat MAX_BYTES, out_idx saturates at MAX_BYTES-1.
- Reset mid-frame: assert rst_n=0 after beat 0 of a 4-byte frame -> out_valid=0 immediately. A following non-first beat sets err.
- MULTIWORD_ADD_OVF_EN:
  - 0x7F+0x01 single byte -> out_ovf=1.
  - 0x80+0x80 -> out_sum 0x00, cout 1, out_ovf=1.
  - 0x01+0x01 -> out_ovf=0.
